ram_block_mover: RTL and testbench

Block-transfer initiator for the 4K x 8 RAM port (`in`/`load`/`address`/`out`). On a start pulse it either copies a byte range or fills a range with a constant, sequencing the RAM port itself, then pulses done. It sits between the CPU/control logic and the RAM4K instance and owns that port while busy.

---
 rtl/ram_block_mover_pkg.sv | 19 +
 rtl/ram_block_mover_ctr.sv | 28 ++
 rtl/ram_block_mover.sv | 160 ++++++++++++++++
 tb/tb_ram_block_mover.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_block_mover_pkg.sv
// Shared types and constants for the RAM block mover.
package ram_block_mover_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 13;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_FILL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram_block_mover_ctr.sv
// Byte counter for the block mover: clear, increment and last-byte flag.
module ram_block_mover_ctr #(
  parameter int LEN_W = ram_block_mover_pkg::LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] count,
  output logic             last
);

  // Counter register; clear has priority over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + LEN_W'(1);
    end
  end

  // The byte being handled now is the final one of the transfer.
  assign last = ((count + LEN_W'(1)) == len);

endmodule

// File: rtl/ram_block_mover.sv
// Block-transfer initiator for the 4K x 8 RAM port: copy or fill a byte range.
// Optional macro RAM_BLOCK_MOVER_CHECKSUM_EN enables the written-byte checksum;
// without it the checksum port is tied to zero.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_IDLE  | waiting for start, RAM port released
// ST_READ  | reading source byte src+i into data reg
// ST_WRITE | writing data reg to dst+i
// ST_FILL  | writing fill byte to dst+i
// ST_DONE  | one-cycle completion pulse
module ram_block_mover
  import ram_block_mover_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out,
  output logic [DATA_W-1:0] checksum
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] fill_q, data_q;
  logic [LEN_W-1:0]  count;
  logic              last, ctr_clr, ctr_inc, ld_cfg;
  logic [ADDR_W-1:0] src_addr, dst_addr;

  ram_block_mover_ctr #(.LEN_W(LEN_W)) u_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (ctr_clr),
    .inc   (ctr_inc),
    .len   (len_q),
    .count (count),
    .last  (last)
  );

  // Addresses wrap naturally at 2^ADDR_W.
  assign src_addr = src_q + ADDR_W'(count);
  assign dst_addr = dst_q + ADDR_W'(count);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Transfer parameters are captured only when a start is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      fill_q <= '0;
    end else if (ld_cfg) begin
      src_q  <= src;
      dst_q  <= dst;
      len_q  <= len;
      fill_q <= fill_val;
    end
  end

  // Data register holds the byte read in READ for the following WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  data_q <= '0;
    else if (state_q == ST_READ) data_q <= ram_out;
  end

  // Next-state and counter control.
  always_comb begin
    state_d = state_q;
    ctr_clr = 1'b0;
    ctr_inc = 1'b0;
    ld_cfg  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ld_cfg  = 1'b1;
          ctr_clr = 1'b1;
          if (len == '0)             state_d = ST_DONE;
          else if (mode == MODE_COPY) state_d = ST_READ;
          else                        state_d = ST_FILL;
        end
      end
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: begin
        ctr_inc = 1'b1;
        state_d = last ? ST_DONE : ST_READ;
      end
      ST_FILL: begin
        ctr_inc = 1'b1;
        state_d = last ? ST_DONE : ST_FILL;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Port outputs decoded from the state register and held registers only,
  // so ram_load falls as soon as reset clears the state.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    ram_load    = 1'b0;
    ram_address = '0;
    ram_in      = '0;
    unique case (state_q)
      ST_READ: begin
        busy        = 1'b1;
        ram_address = src_addr;
      end
      ST_WRITE: begin
        busy        = 1'b1;
        ram_load    = 1'b1;
        ram_address = dst_addr;
        ram_in      = data_q;
      end
      ST_FILL: begin
        busy        = 1'b1;
        ram_load    = 1'b1;
        ram_address = dst_addr;
        ram_in      = fill_q;
      end
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef RAM_BLOCK_MOVER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // Running sum of written bytes, restarted by each accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         sum_q <= '0;
    else if (ld_cfg)   sum_q <= '0;
    else if (ram_load) sum_q <= sum_q + ram_in;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_block_mover.sv
// Directed bench for ram_block_mover with a behavioural 4K x 8 RAM.
module tb_ram_block_mover;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [11:0] src = '0, dst = '0;
  logic [12:0] len = '0;
  logic [7:0]  fill_val = '0;
  logic        busy, done, ram_load;
  logic [11:0] ram_address;
  logic [7:0]  ram_in, ram_out, checksum;

  logic [7:0]  mem [4096];
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  int n_chk = 0, n_err = 0;
  int done_cyc, n_done, n_load, n_busy;
  logic [11:0] wr_addr [8];
  logic [7:0]  wr_data [8];
  int          wr_cyc  [8];

`ifdef RAM_BLOCK_MOVER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  ram_block_mover dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .fill_val    (fill_val),
    .busy        (busy),
    .done        (done),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_out     (ram_out),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  assign ram_out = mem[ram_address];

  always @(posedge clk) begin
    if (pl_we)         mem[pl_addr] <= pl_data;
    else if (ram_load) mem[ram_address] <= ram_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pl(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Launch a transfer and observe it cycle by cycle; cycle 1 follows the start edge.
  task automatic run(input logic m, input logic [11:0] s, input logic [11:0] d,
                     input logic [12:0] l, input logic [7:0] f,
                     input int poke_cyc, input int rst_cyc);
    done_cyc = -1; n_done = 0; n_load = 0; n_busy = 0;
    @(negedge clk);
    mode = m; src = s; dst = d; len = l; fill_val = f; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == poke_cyc) begin
        start = 1'b1; src = 12'h333; dst = 12'h444; len = 13'd1;
        fill_val = 8'h99; mode = ~m;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy) n_busy++;
      if (ram_load) begin
        if (n_load < 8) begin
          wr_addr[n_load] = ram_address;
          wr_data[n_load] = ram_in;
          wr_cyc[n_load]  = c;
        end
        n_load++;
      end
      if (c == rst_cyc) begin
        reset = 1'b1;
        #1;
        check("rst_load", ram_load, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        return;
      end
      if (done_cyc > 0 && c >= done_cyc + 3) return;
    end
    check("done_timeout", 0, 1);
  endtask

  initial begin
    #12;
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_load0", ram_load, 0);
    check("rst_addr0", ram_address, 0);
    check("rst_in0", ram_in, 0);
    check("rst_csum0", checksum, 0);
    @(negedge clk);
    reset = 1'b0;

    // Plain copy
    pl(12'h010, 8'hAA); pl(12'h011, 8'h55); pl(12'h012, 8'h01); pl(12'h013, 8'hFF);
    for (int i = 0; i < 4; i++) pl(12'h800 + 12'(i), 8'h00);
    run(1'b0, 12'h010, 12'h800, 13'd4, 8'h00, -1, -1);
    check("cp_m800", mem[12'h800], 8'hAA);
    check("cp_m801", mem[12'h801], 8'h55);
    check("cp_m802", mem[12'h802], 8'h01);
    check("cp_m803", mem[12'h803], 8'hFF);
    check("cp_done_cyc", done_cyc, 9);
    check("cp_n_done", n_done, 1);
    check("cp_n_load", n_load, 4);
    check("cp_wr0_cyc", wr_cyc[0], 2);
    check("cp_wr3_addr", wr_addr[3], 12'h803);
    check("cp_csum", checksum, CSUM_ON ? 8'hFF : 8'h00);

    // Fill across the top of the address space
    run(1'b1, 12'h000, 12'hFFE, 13'd3, 8'h5A, -1, -1);
    check("fl_wr0_addr", wr_addr[0], 12'hFFE);
    check("fl_wr1_addr", wr_addr[1], 12'hFFF);
    check("fl_wr2_addr", wr_addr[2], 12'h000);
    check("fl_wr0_cyc", wr_cyc[0], 1);
    check("fl_wr2_cyc", wr_cyc[2], 3);
    check("fl_wr2_data", wr_data[2], 8'h5A);
    check("fl_done_cyc", done_cyc, 4);
    check("fl_mFFE", mem[12'hFFE], 8'h5A);
    check("fl_m000", mem[12'h000], 8'h5A);
    check("fl_csum", checksum, CSUM_ON ? 8'h0E : 8'h00);

    // Zero length
    pl(12'h200, 8'h77);
    run(1'b1, 12'h000, 12'h200, 13'd0, 8'h12, -1, -1);
    check("z_done_cyc", done_cyc, 1);
    check("z_busy", n_busy, 0);
    check("z_load", n_load, 0);
    check("z_m200", mem[12'h200], 8'h77);

    // Overlapping ascending copy
    pl(12'h100, 8'h11); pl(12'h101, 8'h22); pl(12'h102, 8'h33); pl(12'h103, 8'h44);
    run(1'b0, 12'h100, 12'h101, 13'd3, 8'h00, -1, -1);
    check("ov_m100", mem[12'h100], 8'h11);
    check("ov_m101", mem[12'h101], 8'h11);
    check("ov_m102", mem[12'h102], 8'h11);
    check("ov_m103", mem[12'h103], 8'h11);
    check("ov_done_cyc", done_cyc, 7);

    // Reset during the write of byte 3 (cycle 6)
    for (int i = 0; i < 4; i++) pl(12'h900 + 12'(i), 8'h00);
    run(1'b0, 12'h010, 12'h900, 13'd4, 8'h00, -1, 6);
    check("rs_m900", mem[12'h900], 8'hAA);
    check("rs_m901", mem[12'h901], 8'h55);
    check("rs_m902", mem[12'h902], 8'h00);
    check("rs_m903", mem[12'h903], 8'h00);
    run(1'b0, 12'h010, 12'h900, 13'd4, 8'h00, -1, -1);
    check("rs2_done_cyc", done_cyc, 9);
    check("rs2_m902", mem[12'h902], 8'h01);
    check("rs2_m903", mem[12'h903], 8'hFF);

    // Start pulse while a fill is running
    for (int i = 0; i < 4; i++) pl(12'h300 + 12'(i), 8'h00);
    pl(12'h444, 8'h00);
    run(1'b1, 12'h000, 12'h300, 13'd4, 8'hC3, 2, -1);
    check("sb_done_cyc", done_cyc, 5);
    check("sb_n_done", n_done, 1);
    check("sb_n_load", n_load, 4);
    check("sb_wr3_addr", wr_addr[3], 12'h303);
    check("sb_m303", mem[12'h303], 8'hC3);
    check("sb_m444", mem[12'h444], 8'h00);
    check("sb_csum", checksum, CSUM_ON ? 8'h0C : 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
